// File: rtl/ad1939_i2s_dac_tx_if.sv
// Sample-pair handshake between the processing fabric and the AD1939 DAC transmitter.
interface ad1939_i2s_dac_tx_if #(
    parameter int unsigned DATA_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/ad1939_i2s_dac_tx.sv
// Master-mode I2S transmitter for the AD1939 DAC serial port: divides clk down to
// DBCLK/DLRCLK and serializes one stereo pair per frame from a single-entry holding register.
module ad1939_i2s_dac_tx #(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned BCLK_DIV = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    ad1939_i2s_dac_tx_if.slave smp,
    output logic               bclk,
    output logic               lrclk,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun
);

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DATA_N   = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] ONE_N    = BIT_W'(1);

    logic [DIV_W-1:0]  div_cnt, div_cnt_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic              hold_full, hold_full_n;
    logic [DATA_W-1:0] hold_left, hold_left_n;
    logic [DATA_W-1:0] hold_right, hold_right_n;
    logic [DATA_W-1:0] left_sr, left_sr_n;
    logic [DATA_W-1:0] right_sr, right_sr_n;
    logic              bclk_n, lrclk_n, sdata_n, frame_start_n, underrun_n;

    logic              right_slot;
    logic [BIT_W-1:0]  slot_k;
    logic              fall;
    logic              frame_evt;
    logic              xfer;

    assign smp.in_ready = !hold_full;

    // Decode slot position and the per-cycle events from the current counter state.
    always_comb begin
        right_slot = (bit_cnt >= SLOT_N);
        slot_k     = right_slot ? (bit_cnt - SLOT_N) : bit_cnt;
        fall       = enable && (div_cnt == '0);
        frame_evt  = fall && (bit_cnt == '0);
        xfer       = smp.in_valid && !hold_full;
    end

    // Next-state for counters, serializer, holding register and output pulses.
    always_comb begin
        div_cnt_n     = div_cnt;
        bit_cnt_n     = bit_cnt;
        hold_full_n   = hold_full;
        hold_left_n   = hold_left;
        hold_right_n  = hold_right;
        left_sr_n     = left_sr;
        right_sr_n    = right_sr;
        bclk_n        = bclk;
        lrclk_n       = lrclk;
        sdata_n       = sdata;
        frame_start_n = 1'b0;
        underrun_n    = 1'b0;

        if (!enable) begin
            div_cnt_n = '0;
            bit_cnt_n = '0;
            bclk_n    = 1'b0;
            lrclk_n   = 1'b0;
            sdata_n   = 1'b0;
        end else begin
            div_cnt_n = (div_cnt == DIV_LAST) ? '0 : (div_cnt + DIV_W'(1));
            if (div_cnt == DIV_LAST) begin
                bit_cnt_n = (bit_cnt == BIT_LAST) ? '0 : (bit_cnt + BIT_W'(1));
            end
            bclk_n = (div_cnt >= DIV_HALF);

            if (fall) begin
                lrclk_n = right_slot;
                sdata_n = 1'b0;
                if ((slot_k >= ONE_N) && (slot_k <= DATA_N)) begin
                    if (right_slot) begin
                        sdata_n    = right_sr[DATA_W-1];
                        right_sr_n = right_sr << 1;
                    end else begin
                        sdata_n    = left_sr[DATA_W-1];
                        left_sr_n  = left_sr << 1;
                    end
                end
            end

            // New frame: take the held pair, or play silence and flag the miss.
            if (frame_evt) begin
                frame_start_n = 1'b1;
                if (hold_full) begin
                    left_sr_n  = hold_left;
                    right_sr_n = hold_right;
                end else begin
                    left_sr_n  = '0;
                    right_sr_n = '0;
                    underrun_n = 1'b1;
                end
            end
        end

        // Capture and release are exclusive: capture needs empty, release needs full.
        if (xfer) begin
            hold_full_n  = 1'b1;
            hold_left_n  = smp.in_left;
            hold_right_n = smp.in_right;
        end else if (frame_evt && hold_full) begin
            hold_full_n  = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            hold_full   <= 1'b0;
            hold_left   <= '0;
            hold_right  <= '0;
            left_sr     <= '0;
            right_sr    <= '0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_n;
            bit_cnt     <= bit_cnt_n;
            hold_full   <= hold_full_n;
            hold_left   <= hold_left_n;
            hold_right  <= hold_right_n;
            left_sr     <= left_sr_n;
            right_sr    <= right_sr_n;
            bclk        <= bclk_n;
            lrclk       <= lrclk_n;
            sdata       <= sdata_n;
            frame_start <= frame_start_n;
            underrun    <= underrun_n;
        end
    end

endmodule

// File: doc/ad1939_i2s_dac_tx.md
Name: ad1939_i2s_dac_tx

Overview:
- Master-mode I2S transmitter for the AD1939 DAC serial port, clocked by the 98.304 MHz system clock that the audio subsystem PLL derives from the codec's 12.288 MHz MCLK.
- Divides the system clock down to DBCLK/DLRCLK. Serializes one stereo sample pair per frame onto DSDATA1.
- Accepts samples from the processing fabric through a single-entry valid/ready holding register.
- Default frame rate: 98.304 MHz / (64 × 32) = 48 kHz.

Parameters:
- DATA_W, 24: sample width, two's complement, MSB-first on the wire.
- SLOT_W, 32: BCLK periods per channel slot. Must satisfy SLOT_W ≥ DATA_W+1.
- BCLK_DIV, 32: system clocks per BCLK period. Must be even and ≥ 4.

Ports:
- clk  in  1  system clock, 98.304 MHz.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  run serial port. Low holds the port idle.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  holding register empty.
- in_left  in  DATA_W  left sample.
- in_right  in  DATA_W  right sample.
- bclk  out  1  DBCLK to codec.
- lrclk  out  1  DLRCLK to codec. 0 = left, 1 = right.
- sdata  out  1  DSDATA1 to codec.
- frame_start  out  1  one-cycle pulse when a new frame begins.
- underrun  out  1  one-cycle pulse when a frame starts with the holding register empty.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: reset_n is sampled on the rising edge of clk and overrides everything.
- Reset values:
  - bclk, lrclk, sdata, frame_start, underrun: 0.
  - Holding register empty, so in_ready = 1.
  - div_cnt = 0, bit_cnt = 0, shift registers 0.
- Counters:
  - div_cnt runs 0..BCLK_DIV-1 and wraps. bit_cnt runs 0..2·SLOT_W-1 and wraps.
  - bit_cnt advances when div_cnt wraps to 0 (the BCLK falling edge).
  - bclk is registered: 0 for div_cnt < BCLK_DIV/2, 1 otherwise. The codec samples on the rising edge.
- Outputs update on the falling edge (div_cnt becoming 0), registered:
  - lrclk = (bit_cnt ≥ SLOT_W).
  - Slot bit k = bit_cnt mod SLOT_W:
    - k = 0: sdata = 0 (I2S one-BCLK delay).
    - 1 ≤ k ≤ DATA_W: sdata = sample[DATA_W-k].
    - k > DATA_W: sdata = 0.
- Frame start (falling edge with bit_cnt = 0):
  - frame_start pulses for one cycle.
  - Holding full: copy left/right into the shift registers and mark the holding register empty.
  - Holding empty: load zeros into both shift registers and pulse underrun for one cycle.
- Handshake:
  - Transfer occurs when in_valid & in_ready at a rising edge. The holding register becomes full the next cycle.
  - in_ready = !full (combinational from the flag).
  - in_left/in_right are ignored when no transfer occurs.
- Simultaneous events:
  - Frame start uses the flag state from before the current edge.
  - Empty holding plus in_valid on the frame-start cycle: the sample is captured into holding, the frame underruns, and the sample plays next frame.
  - Full holding on the frame-start cycle: in_ready was 0, so no capture that cycle.
- Latency: a sample accepted before frame start N has its MSB on sdata 1 BCLK after frame N starts. Left starts 1 BCLK after the lrclk fall; right starts 1 BCLK after the lrclk rise.
- enable low:
  - div_cnt and bit_cnt are forced to 0.
  - bclk, lrclk, sdata are 0. No frame_start or underrun pulses.
  - The holding register and handshake keep working.
- enable rising: frame 0 starts on the first cycle of enable = 1, with div_cnt = 0 and bit_cnt = 0.
- Reset mid-frame: all state returns to reset values on the next edge. The holding contents are discarded.

Test Plan:
- Reset, then enable = 1 with no input.
  - bclk period 32 clk with 50% duty; lrclk period 2048 clk.
  - frame_start every 2048 clk; underrun pulses every frame; sdata stays 0.
- Load left = 24'h800001, right = 24'h7FFFFE before frame 1.
  - Left slot bits 1..24 are 1, 22 × 0, 1; right slot bits are 0, 22 × 1, 0.
  - Slot bit 0 and bits 25..31 are 0. No underrun for that frame.
- Hold in_valid high continuously.
  - Exactly one transfer per frame; in_ready falls the cycle after each transfer and rises the cycle after frame start.
  - No underrun after the first loaded frame.
- Drive in_valid on the exact frame-start cycle with holding empty.
  - underrun pulses in that frame; the sample appears in the following frame.
- Deassert enable mid-frame, then reassert.
  - Outputs drop to 0 the next cycle. The held sample is retained and plays in the first frame after re-enable.
- Assert reset_n = 0 for 1 cycle mid-slot with holding full.
  - All outputs return to 0 and in_ready = 1 on the next edge. The next frame underruns.
